// File: rtl/mux_scan_pkg.sv
// Shared types and sizing helpers for the round-robin mux scan sequencer.
package mux_scan_pkg;

  localparam int NCH  = 4;
  localparam int CH_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2
  } state_e;

  // A dwell of 1 still needs a one-bit counter register.
  function automatic int dwellCntW(input int dwell);
    return ($clog2(dwell) < 1) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts while enabled and pulses tick on its last cycle.
module dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = dwellCntW(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = en && (count_q == LAST);

  // The count wraps to zero on the terminal cycle so the next channel starts fresh.
  always_comb begin
    count_d = count_q;
    if (clr || tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 4-to-1 mux select through all channels, samples each after a dwell,
// and hands the assembled 4-bit snapshot downstream over valid/ready.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           continuous,
  input  logic           abort,
  input  logic           mux_in,
  output logic           s1,
  output logic           s0,
  output logic [NCH-1:0] data,
  output logic           valid,
  input  logic           ready,
  output logic           busy
);

  state_e          state_q, state_d;
  logic            cont_q, cont_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [NCH-2:0]  asm_q, asm_d;
  logic [NCH-1:0]  data_q, data_d;
  logic            tick;

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk (clk),
    .rst (rst),
    .en  (state_q == SCAN),
    .clr (state_q != SCAN),
    .tick(tick)
  );

  // The last channel bypasses asm so the word loads on the same edge it is sampled.
  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    ch_d    = ch_q;
    asm_d   = asm_q;
    data_d  = data_q;
    if (abort) begin
      state_d = IDLE;
      cont_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SCAN;
            cont_d  = continuous;
            ch_d    = '0;
          end
        end
        SCAN: begin
          if (tick) begin
            if (ch_q == CH_W'(NCH - 1)) begin
              data_d  = {mux_in, asm_q};
              state_d = PRESENT;
            end else begin
              asm_d[ch_q] = mux_in;
              ch_d        = ch_q + CH_W'(1);
            end
          end
        end
        PRESENT: begin
          if (ready) begin
            if (cont_q) begin
              state_d = SCAN;
              ch_d    = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cont_q  <= 1'b0;
      ch_q    <= '0;
      asm_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      ch_q    <= ch_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
    end
  end

  // ch_q rests at the last channel while PRESENT, so the select holds 11 there.
  assign {s1, s0} = (state_q == IDLE) ? '0 : ch_q;
  assign data     = data_q;
  assign valid    = (state_q == PRESENT);
  assign busy     = (state_q != IDLE);

endmodule
